// File: rtl/pkt_rr_arbiter_if.sv
// Bundle of the two producer streams and the shared output stream of pkt_rr_arbiter.
// Handshake: a beat transfers on a rising edge where dinX_vld & dinX_rdy; the producer holds
// the beat stable while vld=1 and rdy=0. The output stream has no ready: dout_vld marks a beat.
interface pkt_rr_arbiter_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] din0;
  logic              din0_sop;
  logic              din0_eop;
  logic              din0_vld;
  logic              din0_rdy;
  logic [DATA_W-1:0] din1;
  logic              din1_sop;
  logic              din1_eop;
  logic              din1_vld;
  logic              din1_rdy;
  logic [DATA_W-1:0] dout;
  logic              dout_sop;
  logic              dout_eop;
  logic              dout_vld;
  logic              dout_ch;
  logic              err;

  modport master (
    output din0, din0_sop, din0_eop, din0_vld,
    output din1, din1_sop, din1_eop, din1_vld,
    input  din0_rdy, din1_rdy,
    input  dout, dout_sop, dout_eop, dout_vld, dout_ch, err
  );

  modport slave (
    input  din0, din0_sop, din0_eop, din0_vld,
    input  din1, din1_sop, din1_eop, din1_vld,
    output din0_rdy, din1_rdy,
    output dout, dout_sop, dout_eop, dout_vld, dout_ch, err
  );
endinterface

// File: rtl/pkt_rr_arbiter.sv
// Two-source packet arbiter: round-robin grant per packet, 1-cycle registered output.
// Optional macro PKT_WDOG_EN: truncate packets longer than MAX_LEN beats and pulse err.
module pkt_rr_arbiter #(
  parameter int DATA_W  = 8,
  parameter int MAX_LEN = 64
) (
  input  logic                   clk,
  input  logic                   rst_n,
  pkt_rr_arbiter_if.slave        pkt_if,
  output logic [2:0]             dbg_state_o
);

  if (MAX_LEN < 2 || MAX_LEN > 255) begin : g_max_len_check
    $error("pkt_rr_arbiter: MAX_LEN must be in 2..255");
  end

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    GNT0  = 3'd1,
    GNT1  = 3'd2
`ifdef PKT_WDOG_EN
    ,
    DROP0 = 3'd3,
    DROP1 = 3'd4
`endif
  } state_e;

  state_e            state_q;
  logic              last_q;
  logic [DATA_W-1:0] dout_q;
  logic              dout_sop_q;
  logic              dout_eop_q;
  logic              dout_vld_q;
  logic              dout_ch_q;
`ifdef PKT_WDOG_EN
  localparam logic [7:0] CNT_LAST = 8'(MAX_LEN - 1);
  logic              err_q;
  logic [7:0]        cnt_q;
`endif

  logic              req0, req1, rdy0, rdy1;
  logic              cur_ch, cur_vld, cur_sop, cur_eop;
  logic [DATA_W-1:0] cur_data;

  always_comb begin
    req0   = pkt_if.din0_vld & pkt_if.din0_sop;
    req1   = pkt_if.din1_vld & pkt_if.din1_sop;
    rdy0   = 1'b0;
    rdy1   = 1'b0;
    cur_ch = 1'b0;
    case (state_q)
      IDLE: begin
        // Beats without sop cannot start a packet; drain them so the source unblocks.
        rdy0 = pkt_if.din0_vld & ~pkt_if.din0_sop;
        rdy1 = pkt_if.din1_vld & ~pkt_if.din1_sop;
      end
      GNT0: rdy0 = 1'b1;
      GNT1: begin
        rdy1   = 1'b1;
        cur_ch = 1'b1;
      end
`ifdef PKT_WDOG_EN
      DROP0: rdy0 = 1'b1;
      DROP1: begin
        rdy1   = 1'b1;
        cur_ch = 1'b1;
      end
`endif
      default: ;
    endcase
    cur_vld  = cur_ch ? pkt_if.din1_vld : pkt_if.din0_vld;
    cur_sop  = cur_ch ? pkt_if.din1_sop : pkt_if.din0_sop;
    cur_eop  = cur_ch ? pkt_if.din1_eop : pkt_if.din0_eop;
    cur_data = cur_ch ? pkt_if.din1     : pkt_if.din0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      last_q     <= 1'b1;
      dout_q     <= '0;
      dout_sop_q <= 1'b0;
      dout_eop_q <= 1'b0;
      dout_vld_q <= 1'b0;
      dout_ch_q  <= 1'b0;
`ifdef PKT_WDOG_EN
      err_q      <= 1'b0;
      cnt_q      <= '0;
`endif
    end else begin
`ifdef PKT_WDOG_EN
      err_q <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          dout_vld_q <= 1'b0;
          // On a tie the source that did not send the previous packet wins.
          if (req0 && (!req1 || last_q)) state_q <= GNT0;
          else if (req1)                 state_q <= GNT1;
        end
        GNT0, GNT1: begin
          dout_vld_q <= cur_vld;
          if (cur_vld) begin
            dout_q     <= cur_data;
            dout_sop_q <= cur_sop;
            dout_eop_q <= cur_eop;
            dout_ch_q  <= cur_ch;
`ifdef PKT_WDOG_EN
            if (cur_eop) begin
              state_q <= IDLE;
              last_q  <= cur_ch;
              cnt_q   <= '0;
            end else if (cnt_q == CNT_LAST) begin
              dout_eop_q <= 1'b1;
              err_q      <= 1'b1;
              state_q    <= cur_ch ? DROP1 : DROP0;
              last_q     <= cur_ch;
              cnt_q      <= '0;
            end else begin
              cnt_q <= cnt_q + 8'd1;
            end
`else
            if (cur_eop) begin
              state_q <= IDLE;
              last_q  <= cur_ch;
            end
`endif
          end
        end
`ifdef PKT_WDOG_EN
        DROP0, DROP1: begin
          dout_vld_q <= 1'b0;
          if (cur_vld && cur_eop) state_q <= IDLE;
        end
`endif
        default: state_q <= IDLE;
      endcase
    end
  end

  assign pkt_if.din0_rdy = rdy0;
  assign pkt_if.din1_rdy = rdy1;
  assign pkt_if.dout     = dout_q;
  assign pkt_if.dout_sop = dout_sop_q;
  assign pkt_if.dout_eop = dout_eop_q;
  assign pkt_if.dout_vld = dout_vld_q;
  assign pkt_if.dout_ch  = dout_ch_q;
`ifdef PKT_WDOG_EN
  assign pkt_if.err      = err_q;
`else
  assign pkt_if.err      = 1'b0;
`endif
  assign dbg_state_o     = state_q;

endmodule

// File: doc/pkt_rr_arbiter.md
Name: pkt_rr_arbiter

Overview:
- Two-source packet arbiter that shares one packet output stream (data/sop/eop/vld) between two upstream packet producers.
- Grants at packet granularity with round-robin fairness; a granted source owns the output until its eop beat is transferred.
- Sits in front of the packet FSM datapath so several producers can feed one consumer.
- Output is registered: 1-cycle latency from accepted input beat to output beat.

Parameters:
- DATA_W, 8, width of data bus on all ports.
- MAX_LEN, 64, maximum beats per packet; used only when PKT_WDOG_EN is defined; legal range 2..255.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- din0  input  DATA_W  source 0 data.
- din0_sop  input  1  source 0 start of packet.
- din0_eop  input  1  source 0 end of packet.
- din0_vld  input  1  source 0 beat valid; source holds beat stable until din0_rdy.
- din0_rdy  output  1  source 0 beat accepted this cycle when din0_vld & din0_rdy (combinational from state and inputs).
- din1, din1_sop, din1_eop, din1_vld, din1_rdy: as source 0, for source 1.
- dout  output  DATA_W  registered output data.
- dout_sop  output  1  registered start of packet.
- dout_eop  output  1  registered end of packet.
- dout_vld  output  1  registered beat valid; no backpressure from the consumer.
- dout_ch  output  1  source index of the current output beat.
- err  output  1  one-cycle pulse on watchdog truncation; tied 0 without PKT_WDOG_EN.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; last=1, so source 0 wins the first tie; dout=0, dout_sop=0, dout_eop=0, dout_vld=0, dout_ch=0, err=0; beat counter=0. Reset mid-packet drops the packet silently; no eop is emitted.
- States: IDLE, GNT0, GNT1 (plus DROP0/DROP1 with PKT_WDOG_EN).
- IDLE, request: source x requests when dinx_vld & dinx_sop.
  - Only one requesting: go to GNTx.
  - Both requesting: grant the source != last.
  - No beat is accepted in the arbitration cycle; grant costs exactly 1 idle cycle.
- IDLE, flush: a source with vld=1 and sop=0 is an orphan beat. dinx_rdy=1 for it, and the beat is discarded (never output). Flush and a grant to the other source may happen in the same cycle.
- GNTx: dinx_rdy=1, other rdy=0. Each beat with vld=1 is registered to dout/sop/eop with dout_vld=1 and dout_ch=x next cycle. Cycles with vld=0 give dout_vld=0 next cycle; the other output fields hold.
- GNTx, eop accepted: go to IDLE, last=x.
- GNTx, sop and eop on the same beat: 1-beat packet, same eop rule.
- GNTx, sop mid-packet: forwarded unchanged; no state change.
- Back-to-back: minimum gap of 1 output cycle between the eop of one packet and the sop of the next, from either source.
- Fairness: with both sources continuously requesting, output packets strictly alternate 0,1,0,1...

Optional Feature:
- Macro PKT_WDOG_EN.
- Defined: a beat counter counts accepted beats in GNTx, including the sop beat.
  - If beat MAX_LEN is accepted without eop, that beat is output with dout_eop forced to 1, and err pulses 1 in the same cycle as that output beat.
  - State goes to DROPx, and last=x.
  - DROPx: dinx_rdy=1; all beats are discarded until the eop beat, then IDLE.
  - A packet whose eop arrives exactly on beat MAX_LEN is normal (no err).
- Undefined: no counter, no DROP states, err tied 0, packet length unlimited.

Test Plan:
- Reset release, source 0 sends 3-beat packet 0xA1,0xA2,0xA3 (sop on first, eop on last) -> 1 idle cycle, then dout 0xA1(sop),0xA2,0xA3(eop) on 3 consecutive cycles, dout_ch=0, then state IDLE.
- Both sources assert sop in the same cycle after reset, each sends a 2-beat packet -> source 0 packet output first, 1-cycle gap, then source 1 packet; repeated 4 times gives channel order 0,1,0,1,0,1,0,1.
- Source 1 holds vld low for 2 cycles mid-packet -> dout_vld low for exactly those 2 cycles, din0_rdy stays 0 throughout, and the packet completes intact.
- Source 0 presents orphan beat 0x55 (vld=1, sop=0) in IDLE -> din0_rdy=1 that cycle, no dout_vld; a following sop packet is granted normally.
- rst_n pulsed low for 1 cycle during beat 2 of a 4-beat packet -> all outputs 0 immediately; after release, the next sop from either source is granted with source 0 winning a tie.
- With PKT_WDOG_EN, MAX_LEN=4, source 0 sends 6 beats with eop on beat 6 -> output beats 1-4 with eop forced on beat 4, err=1 for one cycle with beat 4, beats 5-6 consumed but not output, then a pending source 1 packet is granted.
